delta_encoder: RTL

- Sits directly downstream of the AXIS input stream source (stimulus generator in simulation, DMA in system).
- Consumes beats of NUM_PE packed activations and compares each element with the last transmitted value for that feature index.
- Emits only elements whose delta magnitude reaches a threshold, as (index, delta) pairs, one per cycle, closed by an end-of-vector marker beat.
- Output feeds the sparse MAC array's NZI/delta queue.

---
 rtl/delta_pkg.sv | 23 ++
 rtl/delta_lane_cmp.sv | 27 ++
 rtl/delta_encoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/delta_pkg.sv
// Shared types and constants for the delta encoder: FSM encoding, the
// end-of-vector index sentinel and the output word field layout.
package delta_pkg;

  typedef enum logic [1:0] {
    DE_IDLE = 2'd0,
    DE_SCAN = 2'd1,
    DE_EOV  = 2'd2
  } de_state_e;

  // Output word is {index, delta}; the delta occupies the low ACT_BW bits.
  localparam int DELTA_LSB = 0;

  function automatic int idx_lsb(input int act_bw);
    return act_bw;
  endfunction

  // All-ones index of the requested width (up to 32 bits).
  function automatic logic [31:0] eov_idx(input int nzi_bw);
    return 32'hFFFF_FFFF >> (32 - nzi_bw);
  endfunction

endpackage

// File: rtl/delta_lane_cmp.sv
// Single-lane delta: saturated signed difference against the stored value,
// plus a fire flag when the magnitude reaches the threshold.
module delta_lane_cmp #(
  parameter int ACT_BW = 8
) (
  input  logic [ACT_BW-1:0] x,
  input  logic [ACT_BW-1:0] prev,
  input  logic [ACT_BW-1:0] th,
  output logic [ACT_BW-1:0] delta,
  output logic              fire
);

  logic [ACT_BW:0] diff;
  logic [ACT_BW:0] mag;

  always_comb begin
    diff = {x[ACT_BW-1], x} - {prev[ACT_BW-1], prev};
    // Top two bits disagree only when the difference left the ACT_BW range.
    if (diff[ACT_BW] != diff[ACT_BW-1])
      delta = diff[ACT_BW] ? {1'b1, {(ACT_BW-1){1'b0}}} : {1'b0, {(ACT_BW-1){1'b1}}};
    else
      delta = diff[ACT_BW-1:0];
    mag  = delta[ACT_BW-1] ? (~{1'b1, delta} + 1'b1) : {1'b0, delta};
    fire = mag >= {1'b0, th};
  end

endmodule

// File: rtl/delta_encoder.sv
// Delta encoder: scans each accepted beat one lane per cycle, emitting
// (index, delta) words for elements whose change reaches the threshold.
module delta_encoder
  import delta_pkg::*;
#(
  parameter int NUM_PE  = 8,
  parameter int ACT_BW  = 8,
  parameter int NZI_BW  = 16,
  parameter int VEC_LEN = 64
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_areset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [NUM_PE*ACT_BW-1:0] s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic [ACT_BW-1:0]        th,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [NZI_BW+ACT_BW-1:0] m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     err_len
);

  localparam int LW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [NZI_BW-1:0] EOV_IDX = NZI_BW'(eov_idx(NZI_BW));
  localparam logic [NZI_BW-1:0] STEP    = NZI_BW'(NUM_PE);
  localparam logic [NZI_BW-1:0] LEN     = NZI_BW'(VEC_LEN);

  de_state_e state, state_nxt;

  logic [NUM_PE*ACT_BW-1:0] data_r;
  logic                     last_r;
  logic [ACT_BW-1:0]        th_r;
  logic [LW-1:0]            lane;
  logic [NZI_BW-1:0]        elem_cnt;
  logic [NZI_BW-1:0]        idx;
  logic [ACT_BW-1:0]        prev_mem [VEC_LEN];

  logic [ACT_BW-1:0] x_sel, prev_sel, delta;
  logic              fire, accept, step, lane_last, vec_done;

  assign idx       = elem_cnt + NZI_BW'(lane);
  assign x_sel     = data_r[lane*ACT_BW +: ACT_BW];
  assign prev_sel  = prev_mem[idx[IW-1:0]];
  assign lane_last = (lane == LW'(NUM_PE - 1));
  assign vec_done  = ((elem_cnt + STEP) == LEN);

  delta_lane_cmp #(.ACT_BW(ACT_BW)) u_cmp (
    .x     (x_sel),
    .prev  (prev_sel),
    .th    (th_r),
    .delta (delta),
    .fire  (fire)
  );

  assign s_axis_tready = (state == DE_IDLE) & ~s_axi_areset;
  assign accept        = s_axis_tvalid & s_axis_tready;
  // A suppressed lane advances at once; a firing lane waits for its handshake.
  assign step          = (state == DE_SCAN) & (~fire | m_axis_tready);

  always_comb begin
    state_nxt     = state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (state)
      DE_IDLE: if (accept) state_nxt = DE_SCAN;
      DE_SCAN: begin
        if (fire) begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = {idx, delta};
        end
        if (step && lane_last) state_nxt = vec_done ? DE_EOV : DE_IDLE;
      end
      DE_EOV: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {EOV_IDX, ACT_BW'(0)};
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) state_nxt = DE_IDLE;
      end
      default: state_nxt = DE_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state    <= DE_IDLE;
      data_r   <= '0;
      last_r   <= 1'b0;
      th_r     <= '0;
      lane     <= '0;
      elem_cnt <= '0;
      err_len  <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) prev_mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_r <= s_axis_tdata;
        last_r <= s_axis_tlast;
        th_r   <= th;
        lane   <= '0;
        // Early tlast is visible as soon as the beat is taken.
        if (s_axis_tlast && !vec_done) err_len <= 1'b1;
      end
      if (step) begin
        if (fire) prev_mem[idx[IW-1:0]] <= x_sel;
        lane <= lane + LW'(1);
        if (lane_last) begin
          elem_cnt <= vec_done ? '0 : elem_cnt + STEP;
          if (vec_done && !last_r) err_len <= 1'b1;
        end
      end
    end
  end

endmodule
